// File: rtl/urv_typedef.sv
// urv_typedef: shared types for the uRV memory subsystem.
//   mem_req_t   - burst request (type, address, write data, byte mask, burst length)
//   mem_resp_t  - response beat (read data, echoed type, last-beat flag)
//   arb_state_t - burst arbiter state (idle / burst in progress)
package urv_typedef;

    localparam int MEM_ADDR_W  = 32;
    localparam int MEM_DATA_W  = 32;
    localparam int MEM_MASK_W  = 4;
    localparam int MEM_BURST_W = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef struct packed {
        logic                   req_type;
        logic [MEM_ADDR_W-1:0]  req_addr;
        logic [MEM_DATA_W-1:0]  req_data;
        logic [MEM_MASK_W-1:0]  req_mask;
        logic [MEM_BURST_W-1:0] req_burst;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] resp_data;
        logic                  resp_type;
        logic                  resp_last;
    } mem_resp_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/urv_arb2_gnt.sv
// urv_arb2_gnt: two-way grant select for urv_mem_arb2.
// Build option: URV_MEM_ARB_RR_EN selects round-robin (1-bit preference
// pointer, updated on every grant); otherwise master 0 has fixed priority
// and no state is built.
// Ports:
//   clk, rst  - clock / synchronous active-high reset (round-robin build only)
//   advance   - a grant was taken this cycle (round-robin build only)
//   req0/req1 - master request valids
//   gnt       - selected master index (0 when nobody requests)
module urv_arb2_gnt (
`ifdef URV_MEM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic advance,
`endif
    input  logic req0,
    input  logic req1,
    output logic gnt
);

`ifdef URV_MEM_ARB_RR_EN
    logic ptr_reg;

    // Contention resolves to the pointer; a lone requester always wins.
    always_comb begin
        gnt = req1;
        if (req0 && req1) begin
            gnt = ptr_reg;
        end
    end

    // The master just served becomes the less preferred one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= ~gnt;
        end
    end
`else
    assign gnt = ~req0 & req1;
`endif

endmodule

// File: rtl/urv_mem_arb2.sv
// urv_mem_arb2: two-master burst arbiter in front of the mem_if SRAM bridge.
// One burst is granted at a time; the grant is held until the beat flagged
// resp_last is accepted, and response beats are routed to the owning master.
// Build option: URV_MEM_ARB_RR_EN = round-robin, else master 0 fixed priority.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   m0_*/m1_* req_valid/ready/req   master request channels
//   m0_*/m1_* resp_valid/ready/resp master response channels
//   mem_req_valid/ready, mem_req    downstream request
//   mem_resp_valid/ready, mem_resp  downstream response beats
//   err_burst                       sticky beat-count / last / drop error
module urv_mem_arb2
    import urv_typedef::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      m0_req_valid,
    output logic      m0_req_ready,
    input  mem_req_t  m0_req,
    output logic      m0_resp_valid,
    input  logic      m0_resp_ready,
    output mem_resp_t m0_resp,
    input  logic      m1_req_valid,
    output logic      m1_req_ready,
    input  mem_req_t  m1_req,
    output logic      m1_resp_valid,
    input  logic      m1_resp_ready,
    output mem_resp_t m1_resp,
    output logic      mem_req_valid,
    input  logic      mem_req_ready,
    output mem_req_t  mem_req,
    input  logic      mem_resp_valid,
    output logic      mem_resp_ready,
    input  mem_resp_t mem_resp,
    output logic      err_burst
);

    arb_state_t             state_reg;
    logic                   owner_reg;
    logic [MEM_BURST_W-1:0] beats_reg;
    logic                   err_burst_reg;

    logic gnt;
    logic idle;
    logic busy;
    logic req_fire;
    logic beat_fire;
    logic beat_drop;
    logic terminal;

    assign idle = (state_reg == ARB_IDLE);
    assign busy = (state_reg == ARB_BUSY);

    urv_arb2_gnt u_gnt (
`ifdef URV_MEM_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
        .advance (req_fire),
`endif
        .req0    (m0_req_valid),
        .req1    (m1_req_valid),
        .gnt     (gnt)
    );

    // Request path: pure pass-through of the granted master while idle.
    assign mem_req       = gnt ? m1_req : m0_req;
    assign mem_req_valid = idle & (gnt ? m1_req_valid : m0_req_valid);
    assign m0_req_ready  = idle & ~gnt & mem_req_ready;
    assign m1_req_ready  = idle &  gnt & mem_req_ready;
    assign req_fire      = mem_req_valid & mem_req_ready;

    // Response path: data fans out to both, valid only to the owner.
    assign m0_resp        = mem_resp;
    assign m1_resp        = mem_resp;
    assign m0_resp_valid  = busy & ~owner_reg & mem_resp_valid;
    assign m1_resp_valid  = busy &  owner_reg & mem_resp_valid;
    assign mem_resp_ready = busy & (owner_reg ? m1_resp_ready : m0_resp_ready);

    assign beat_fire = mem_resp_valid & mem_resp_ready;
    // The bridge cannot be back-pressured, so an unaccepted beat is lost.
    assign beat_drop = busy & mem_resp_valid & ~mem_resp_ready;
    assign terminal  = (beats_reg == {{(MEM_BURST_W-1){1'b0}}, 1'b1});

    assign err_burst = err_burst_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            owner_reg     <= 1'b0;
            beats_reg     <= '0;
            err_burst_reg <= 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (req_fire) begin
                        state_reg <= ARB_BUSY;
                        owner_reg <= gnt;
                        beats_reg <= mem_req.req_burst;
                        // A zero-length burst is still tracked to resp_last.
                        if (mem_req.req_burst == '0) begin
                            err_burst_reg <= 1'b1;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (beat_fire) begin
                        beats_reg <= beats_reg - 1'b1;
                        if (mem_resp.resp_last != terminal) begin
                            err_burst_reg <= 1'b1;
                        end
                        // resp_last ends the burst even if the count disagrees.
                        if (mem_resp.resp_last) begin
                            state_reg <= ARB_IDLE;
                        end
                    end
                    if (beat_drop) begin
                        err_burst_reg <= 1'b1;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urv_mem_arb2.sv
module tb_urv_mem_arb2;
    import urv_typedef::*;

    logic      clk;
    logic      rst;
    logic      m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic      m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    mem_req_t  m0_req, m1_req, mem_req;
    mem_resp_t m0_resp, m1_resp, mem_resp;
    logic      mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
    logic      err_burst;

    int checks = 0;
    int errors = 0;

    urv_mem_arb2 dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_req         (m0_req),
        .m0_resp_valid  (m0_resp_valid),
        .m0_resp_ready  (m0_resp_ready),
        .m0_resp        (m0_resp),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_req         (m1_req),
        .m1_resp_valid  (m1_resp_valid),
        .m1_resp_ready  (m1_resp_ready),
        .m1_resp        (m1_resp),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req        (mem_req),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp       (mem_resp),
        .err_burst      (err_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mem_req_t make_req(input logic t, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] m,
                                          input logic [7:0] b);
        mem_req_t r;
        r.req_type  = t;
        r.req_addr  = a;
        r.req_data  = d;
        r.req_mask  = m;
        r.req_burst = b;
        return r;
    endfunction

    function automatic mem_resp_t make_resp(input logic [31:0] d, input logic t,
                                            input logic l);
        mem_resp_t r;
        r.resp_data = d;
        r.resp_type = t;
        r.resp_last = l;
        return r;
    endfunction

    // Inputs change on the falling edge; checks happen 1 ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b1;
        m0_req_valid   = 1'b0;
        m1_req_valid   = 1'b0;
        m0_req         = '0;
        m1_req         = '0;
        m0_resp_ready  = 1'b0;
        m1_resp_ready  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp       = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({mem_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
             mem_resp_ready, err_burst} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000000", {mem_req_valid, m0_req_ready,
                     m1_req_ready, m0_resp_valid, m1_resp_valid, mem_resp_ready, err_burst});
        end
        m1_req_valid = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_passthru got=%b exp=1", mem_req_valid);
        end
        m1_req_valid = 1'b0;
        $display("[tb] reset: outputs idle, valid pass-through");
    endtask

    task automatic test_single_read();
        apply_reset();
        m0_req_valid  = 1'b1;
        m0_req        = make_req(MEM_READ, 32'h100, 32'h0, 4'hF, 8'd4);
        mem_req_ready = 1'b1;
        m0_resp_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, m0_req_ready, m1_req_ready} !== 3'b110 ||
            mem_req.req_addr !== 32'h100 || mem_req.req_burst !== 8'd4) begin
            errors++;
            $display("FAIL rd_req vrr=%b addr=%h burst=%0d exp vrr=110 addr=100 burst=4",
                     {mem_req_valid, m0_req_ready, m1_req_ready}, mem_req.req_addr,
                     mem_req.req_burst);
        end
        step();
        m0_req_valid  = 1'b0;
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp       = make_resp(32'hA0 + i, MEM_READ, i == 4);
            #1;
            checks++;
            if ({m0_resp_valid, m1_resp_valid, mem_resp_ready} !== 3'b101 ||
                m0_resp.resp_data !== 32'hA0 + i || m0_resp.resp_last !== (i == 4)) begin
                errors++;
                $display("FAIL rd_beat%0d vvr=%b data=%h last=%b exp vvr=101 data=%h last=%b",
                         i, {m0_resp_valid, m1_resp_valid, mem_resp_ready},
                         m0_resp.resp_data, m0_resp.resp_last, 32'hA0 + i, i == 4);
            end
            $display("[tb] single_read beat %0d", i);
            step();
        end
        mem_resp_valid = 1'b0;
        m1_req_valid   = 1'b1;
        m1_req         = make_req(MEM_READ, 32'h200, 32'h0, 4'hF, 8'd1);
        mem_req_ready  = 1'b1;
        #1;
        checks++;
        if (m1_req_ready !== 1'b1 || err_burst !== 1'b0) begin
            errors++;
            $display("FAIL rd_done m1_ready=%b err=%b exp 1 0", m1_req_ready, err_burst);
        end
        m1_req_valid = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic exp_m1;
        apply_reset();
        m0_req        = make_req(MEM_READ, 32'h300, 32'h0, 4'hF, 8'd2);
        m1_req        = make_req(MEM_READ, 32'h400, 32'h0, 4'hF, 8'd2);
        m0_req_valid  = 1'b1;
        m1_req_valid  = 1'b1;
        mem_req_ready = 1'b1;
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        #1;
        checks++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10 || mem_req.req_addr !== 32'h300) begin
            errors++;
            $display("FAIL sim_first rdy=%b addr=%h exp rdy=10 addr=300",
                     {m0_req_ready, m1_req_ready}, mem_req.req_addr);
        end
        step();
        #1;
        checks++;
        if ({mem_req_valid, m0_req_ready, m1_req_ready} !== 3'b000) begin
            errors++;
            $display("FAIL sim_busy_block got=%b exp=000",
                     {mem_req_valid, m0_req_ready, m1_req_ready});
        end
        for (int i = 1; i <= 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp       = make_resp(32'hB0 + i, MEM_READ, i == 2);
            #1;
            checks++;
            if ({m0_resp_valid, m1_resp_valid} !== 2'b10) begin
                errors++;
                $display("FAIL sim_m0_beat%0d got=%b exp=10", i, {m0_resp_valid, m1_resp_valid});
            end
            step();
        end
        mem_resp_valid = 1'b0;
        // m0 re-requests right away; m1 has been holding its request.
`ifdef URV_MEM_ARB_RR_EN
        exp_m1 = 1'b1;
`else
        exp_m1 = 1'b0;
`endif
        #1;
        checks++;
        if ({m0_req_ready, m1_req_ready} !== {~exp_m1, exp_m1} ||
            mem_req.req_addr !== (exp_m1 ? 32'h400 : 32'h300)) begin
            errors++;
            $display("FAIL sim_second rdy=%b addr=%h exp rdy=%b addr=%h",
                     {m0_req_ready, m1_req_ready}, mem_req.req_addr, {~exp_m1, exp_m1},
                     exp_m1 ? 32'h400 : 32'h300);
        end
        $display("[tb] simultaneous: second grant to m%0d", exp_m1);
        step();
        for (int i = 1; i <= 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp       = make_resp(32'hC0 + i, MEM_READ, i == 2);
            #1;
            checks++;
            if ({m0_resp_valid, m1_resp_valid} !== {~exp_m1, exp_m1}) begin
                errors++;
                $display("FAIL sim_2nd_beat%0d got=%b exp=%b", i,
                         {m0_resp_valid, m1_resp_valid}, {~exp_m1, exp_m1});
            end
            step();
        end
        mem_resp_valid = 1'b0;
        #1;
        // Third round: round-robin returns to m0, fixed priority keeps m0.
        checks++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL sim_third rdy=%b exp=10", {m0_req_ready, m1_req_ready});
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    task automatic test_write_single();
        apply_reset();
        m1_req_valid  = 1'b1;
        m1_req        = make_req(MEM_WRITE, 32'h500, 32'hDEADBEEF, 4'hF, 8'd1);
        mem_req_ready = 1'b1;
        m1_resp_ready = 1'b1;
        #1;
        checks++;
        if (m1_req_ready !== 1'b1 || mem_req.req_type !== MEM_WRITE ||
            mem_req.req_mask !== 4'hF || mem_req.req_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_req rdy=%b type=%b mask=%h data=%h exp 1 1 f deadbeef",
                     m1_req_ready, mem_req.req_type, mem_req.req_mask, mem_req.req_data);
        end
        step();
        m1_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp       = make_resp(32'h0, MEM_WRITE, 1'b1);
        #1;
        checks++;
        if ({m0_resp_valid, m1_resp_valid, mem_resp_ready} !== 3'b011 ||
            m1_resp.resp_type !== MEM_WRITE) begin
            errors++;
            $display("FAIL wr_beat vvr=%b type=%b exp vvr=011 type=1",
                     {m0_resp_valid, m1_resp_valid, mem_resp_ready}, m1_resp.resp_type);
        end
        step();
        mem_resp_valid = 1'b0;
        m0_req_valid   = 1'b1;
        m0_req         = make_req(MEM_READ, 32'h600, 32'h0, 4'hF, 8'd1);
        #1;
        checks++;
        if (m0_req_ready !== 1'b1 || m0_resp_valid !== 1'b0 || err_burst !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle rdy=%b m0_rv=%b err=%b exp 1 0 0",
                     m0_req_ready, m0_resp_valid, err_burst);
        end
        m0_req_valid = 1'b0;
        $display("[tb] write_single: one beat to m1");
    endtask

    task automatic test_short_burst();
        apply_reset();
        m0_req_valid  = 1'b1;
        m0_req        = make_req(MEM_READ, 32'h700, 32'h0, 4'hF, 8'd3);
        mem_req_ready = 1'b1;
        m0_resp_ready = 1'b1;
        step();
        m0_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp       = make_resp(32'h1, MEM_READ, 1'b0);
        step();
        checks++;
        if (err_burst !== 1'b0) begin
            errors++;
            $display("FAIL short_beat1 err=%b exp=0", err_burst);
        end
        mem_resp = make_resp(32'h2, MEM_READ, 1'b1);
        step();
        mem_resp_valid = 1'b0;
        m0_req_valid   = 1'b1;
        m0_req         = make_req(MEM_READ, 32'h710, 32'h0, 4'hF, 8'd1);
        #1;
        checks++;
        if (err_burst !== 1'b1 || m0_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_end err=%b rdy=%b exp 1 1", err_burst, m0_req_ready);
        end
        // A clean single-beat burst must not clear the sticky flag.
        step();
        m0_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp       = make_resp(32'h3, MEM_READ, 1'b1);
        step();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_burst !== 1'b1) begin
            errors++;
            $display("FAIL short_sticky err=%b exp=1", err_burst);
        end
        $display("[tb] short_burst: early last flagged");
    endtask

    task automatic test_zero_burst();
        apply_reset();
        m1_req_valid  = 1'b1;
        m1_req        = make_req(MEM_READ, 32'h800, 32'h0, 4'hF, 8'd0);
        mem_req_ready = 1'b1;
        m1_resp_ready = 1'b1;
        #1;
        checks++;
        if (err_burst !== 1'b0) begin
            errors++;
            $display("FAIL zero_pre err=%b exp=0", err_burst);
        end
        step();
        m1_req_valid = 1'b0;
        #1;
        checks++;
        if (err_burst !== 1'b1) begin
            errors++;
            $display("FAIL zero_grant err=%b exp=1", err_burst);
        end
        for (int i = 1; i <= 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp       = make_resp(32'hD0 + i, MEM_READ, i == 2);
            #1;
            checks++;
            if (m1_resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL zero_beat%0d m1_rv=%b exp=1", i, m1_resp_valid);
            end
            step();
        end
        mem_resp_valid = 1'b0;
        m0_req_valid   = 1'b1;
        m0_req         = make_req(MEM_READ, 32'h810, 32'h0, 4'hF, 8'd1);
        #1;
        checks++;
        if (m0_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle rdy=%b exp=1", m0_req_ready);
        end
        m0_req_valid = 1'b0;
        $display("[tb] zero_burst: flagged, ended on last");
    endtask

    task automatic test_drop();
        apply_reset();
        m0_req_valid  = 1'b1;
        m0_req        = make_req(MEM_READ, 32'h900, 32'h0, 4'hF, 8'd2);
        mem_req_ready = 1'b1;
        m0_resp_ready = 1'b0;
        step();
        m0_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp       = make_resp(32'h9, MEM_READ, 1'b0);
        #1;
        checks++;
        if (mem_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready got=%b exp=0", mem_resp_ready);
        end
        step();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (err_burst !== 1'b1) begin
            errors++;
            $display("FAIL drop_err err=%b exp=1", err_burst);
        end
        $display("[tb] drop: unaccepted beat flagged");
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        m0_req_valid  = 1'b1;
        m0_req        = make_req(MEM_READ, 32'hA00, 32'h0, 4'hF, 8'd4);
        mem_req_ready = 1'b1;
        m0_resp_ready = 1'b1;
        step();
        m0_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp       = make_resp(32'hE1, MEM_READ, 1'b0);
        step();
        mem_resp = make_resp(32'hE2, MEM_READ, 1'b0);
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        mem_resp = make_resp(32'hE3, MEM_READ, 1'b0);
        #1;
        checks++;
        if ({m0_resp_valid, m1_resp_valid, mem_resp_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_route got=%b exp=000",
                     {m0_resp_valid, m1_resp_valid, mem_resp_ready});
        end
        m1_req_valid = 1'b1;
        m1_req       = make_req(MEM_READ, 32'hB00, 32'h0, 4'hF, 8'd1);
        #1;
        checks++;
        if (m1_req_ready !== 1'b1 || err_burst !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle rdy=%b err=%b exp 1 0", m1_req_ready, err_burst);
        end
        m1_req_valid   = 1'b0;
        mem_resp_valid = 1'b0;
        $display("[tb] reset_mid_burst: routing stopped");
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write_single();
        test_short_burst();
        test_zero_burst();
        test_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
